// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the unified-memory port arbiter.
//             arb_state_t  - arbiter FSM states
//             arb_owner_t  - which requester owns the current transaction
//             IF_FUNCT3    - access size issued for instruction fetches (word)
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam logic [2:0] IF_FUNCT3 = 3'b010;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pick
//  Purpose  : Combinational winner selection between fetch (IF) and MEM-stage
//             data (DM) requests. DM is the older instruction and normally
//             wins; IF is forced once the DM streak counter is saturated.
//  Ports    : if_req      in  fetch request
//             dm_req      in  data request
//             streak_full in  DM streak has reached its limit
//             grant_valid out some requester can be granted
//             owner       out selected requester
//  Revision : 1.0  initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       streak_full,
    output logic       grant_valid,
    output arb_owner_t owner
);

    always_comb begin
        grant_valid = if_req | dm_req;
        owner       = OWN_IF;
        if (dm_req && !(if_req && streak_full)) begin
            owner = OWN_DM;
        end
    end

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported instruction/data memory between the
//             fetch stage (IF) and the MEM stage (DM). One registered command
//             per transaction, fixed read latency, one-cycle valid pulse.
//  Ports    : clk, reset (async, active-low)
//             if_req/if_addr           -> if_rdata/if_valid/if_stall
//             dm_req/dm_we/dm_addr/dm_wdata/dm_funct3
//                                      -> dm_rdata/dm_valid/dm_stall
//             mem_en/mem_we/mem_addr/mem_wdata/mem_funct3 -> memory command
//             mem_rdata                <- memory read data
//  Timing   : decision in IDLE at t0, mem_en at t0+1, read data captured
//             MEM_LAT cycles after mem_en, valid at t0+MEM_LAT+2 (first IDLE
//             cycle, in which the next grant may also be decided).
//             A requester still holding req in its own valid cycle is seen
//             as presenting a new request.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_LAT_W    = $clog2(MEM_LAT + 1);
    localparam int c_STREAK_W = $clog2(STARVE_MAX + 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    arb_owner_t              r_owner;
    arb_owner_t              w_owner;
    logic                    w_grant_valid;
    logic                    w_grant;
    logic                    w_last;
    logic                    r_is_write;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [c_STREAK_W-1:0]   r_streak;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [2:0]              r_mem_funct3;
    logic [DATA_W-1:0]       r_if_rdata;
    logic [DATA_W-1:0]       r_dm_rdata;
    logic                    r_if_valid;
    logic                    r_dm_valid;

    arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .streak_full (r_streak == c_STREAK_W'(STARVE_MAX)),
        .grant_valid (w_grant_valid),
        .owner       (w_owner)
    );

    assign w_grant = (r_state == ARB_IDLE) && w_grant_valid;
    // lat_cnt is 0 during the mem_en cycle and reloads at its end, so the
    // value 1 marks the cycle MEM_LAT cycles after mem_en.
    assign w_last  = (r_state == ARB_BUSY) && (r_lat_cnt == c_LAT_W'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant_valid) w_state_nxt = ARB_BUSY;
            ARB_BUSY: if (w_last)        w_state_nxt = ARB_IDLE;
            default:                     w_state_nxt = ARB_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem_en     = r_mem_en;
        mem_we     = r_mem_we;
        mem_addr   = r_mem_addr;
        mem_wdata  = r_mem_wdata;
        mem_funct3 = r_mem_funct3;
        if_rdata   = r_if_rdata;
        dm_rdata   = r_dm_rdata;
        if_valid   = r_if_valid;
        dm_valid   = r_dm_valid;
        if_stall   = if_req & ~r_if_valid;
        dm_stall   = dm_req & ~r_dm_valid;
    end

    // ---------------- command, counters and response registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWN_IF;
            r_is_write   <= 1'b0;
            r_lat_cnt    <= '0;
            r_streak     <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_funct3 <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;

            if (w_grant) begin
                r_mem_en <= 1'b1;
                r_owner  <= w_owner;
                if (w_owner == OWN_DM) begin
                    r_mem_we     <= dm_we;
                    r_is_write   <= dm_we;
                    r_mem_addr   <= dm_addr;
                    r_mem_wdata  <= dm_wdata;
                    r_mem_funct3 <= dm_funct3;
                    // Streak only counts DM grants that made a fetch wait.
                    if (!if_req) begin
                        r_streak <= '0;
                    end else if (r_streak != c_STREAK_W'(STARVE_MAX)) begin
                        r_streak <= r_streak + c_STREAK_W'(1);
                    end
                end else begin
                    r_is_write   <= 1'b0;
                    r_mem_addr   <= if_addr;
                    r_mem_funct3 <= IF_FUNCT3;
                    r_streak     <= '0;
                end
            end

            if (r_mem_en) begin
                r_lat_cnt <= c_LAT_W'(MEM_LAT);
            end else if (r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end

            if (w_last) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_rdata;
                    r_if_valid <= 1'b1;
                end else begin
                    if (!r_is_write) begin
                        r_dm_rdata <= mem_rdata;
                    end
                    r_dm_valid <= 1'b1;
                end
            end
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with a
//             latency-accurate ROM model and a command/response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [2:0]        dm_funct3 = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic              is_dm;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        f3;
    } cmd_t;

    cmd_t        cmd_q[$];
    cmd_t        rsp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_dm = '0;

    function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
        return (a == 9'h010) ? 32'h00500093 : ({16'hC0DE, 7'd0, a} ^ {a, 23'd0});
    endfunction

    // Memory model: read data for a command is present exactly MEM_LAT
    // cycles after its mem_en cycle, garbage otherwise.
    logic [MEM_LAT-1:0] pipe_v = '0;
    logic [ADDR_W-1:0]  pipe_a [MEM_LAT];
    always @(posedge clk) begin
        pipe_v[0] <= mem_en;
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign mem_rdata = pipe_v[MEM_LAT-1] ? rom(pipe_a[MEM_LAT-1]) : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic is_dm, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [2:0] f3);
        cmd_t c;
        c.is_dm = is_dm; c.we = we; c.addr = a; c.wdata = wd; c.f3 = f3;
        cmd_q.push_back(c);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        cmd_t c;
        cmd_t r;
        if (mem_en) begin
            if (cmd_q.size() == 0) begin
                check("mem_en_unexpected", 32'(mem_en), 32'd0);
            end else begin
                c = cmd_q.pop_front();
                check("cmd_addr", 32'(mem_addr), 32'(c.addr));
                check("cmd_we", 32'(mem_we), 32'(c.we));
                check("cmd_funct3", 32'(mem_funct3), 32'(c.f3));
                if (c.we) check("cmd_wdata", mem_wdata, c.wdata);
                rsp_q.push_back(c);
            end
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
        end
        if (if_valid || dm_valid) begin
            if (rsp_q.size() == 0) begin
                check("valid_unexpected", 32'({if_valid, dm_valid}), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                check("valid_owner", 32'({if_valid, dm_valid}), r.is_dm ? 32'd1 : 32'd2);
                if (!r.is_dm) begin
                    check("if_rdata", if_rdata, rom(r.addr));
                end else if (!r.we) begin
                    last_dm = rom(r.addr);
                    check("dm_rdata", dm_rdata, last_dm);
                end else begin
                    check("dm_rdata_kept", dm_rdata, last_dm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({mem_en, mem_we, if_valid, dm_valid, mem_funct3}), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_mem_addr_wdata", 32'(mem_addr) | mem_wdata, 32'd0);
        if_req = 1'b1;
        #1;
        check("rst_if_stall", 32'(if_stall), 32'd1);
        if_req = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        // ---------------- 1: lone IF read ----------------
        if_req = 1'b1; if_addr = 9'h010;
        push_cmd(1'b0, 1'b0, 9'h010, '0, 3'b010);
        #1 check("t1_stall_t0", 32'(if_stall), 32'd1);
        cyc();
        check("t1_mem_en", 32'({mem_en, mem_we}), 32'd2);
        check("t1_mem_addr", 32'(mem_addr), 32'h010);
        check("t1_funct3", 32'(mem_funct3), 32'd2);
        cyc();
        check("t1_mem_en_once", 32'(mem_en), 32'd0);
        cyc();
        check("t1_stall_t3", 32'({if_stall, if_valid}), 32'd2);
        cyc();
        check("t1_valid_t4", 32'({if_valid, if_stall}), 32'd2);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        if_req = 1'b0;
        cyc();
        check("t1_valid_pulse", 32'(if_valid), 32'd0);

        // ---------------- 2: simultaneous IF + DM ----------------
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h020; dm_funct3 = 3'b010;
        if_req = 1'b1; if_addr = 9'h030;
        push_cmd(1'b1, 1'b0, 9'h020, '0, 3'b010);
        push_cmd(1'b0, 1'b0, 9'h030, '0, 3'b010);
        cyc();
        check("t2_dm_first", 32'({mem_en, mem_addr}), 32'({1'b1, 9'h020}));
        repeat (3) cyc();
        check("t2_dm_valid_t4", 32'({dm_valid, if_stall}), 32'd3);
        dm_req = 1'b0;
        cyc();
        check("t2_if_issue_t5", 32'({mem_en, mem_addr}), 32'({1'b1, 9'h030}));
        repeat (3) cyc();
        check("t2_if_valid_t8", 32'(if_valid), 32'd1);
        if_req = 1'b0;
        cyc();

        // ---------------- 3: DM streak, IF forced after STARVE_MAX ----------------
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h040; dm_funct3 = 3'b000;
        if_req = 1'b1; if_addr = 9'h050;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push_cmd(1'b0, 1'b0, 9'h050, '0, 3'b010);
            else        push_cmd(1'b1, 1'b0, 9'h040, '0, 3'b000);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t3_grant_addr", 32'({mem_en, mem_addr}),
                  32'({1'b1, (k == 4) ? 9'h050 : 9'h040}));
            check("t3_streak", 32'(dut.r_streak), (k < 4) ? 32'(k + 1) : 32'd0);
            repeat (3) cyc();
            if (k == 4) if_req = 1'b0;
            if (k == 5) dm_req = 1'b0;
        end
        cyc();

        // ---------------- 4: DM write ----------------
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h024; dm_wdata = 32'hDEADBEEF; dm_funct3 = 3'b010;
        push_cmd(1'b1, 1'b1, 9'h024, 32'hDEADBEEF, 3'b010);
        cyc();
        check("t4_en_we", 32'({mem_en, mem_we}), 32'd3);
        check("t4_wdata", mem_wdata, 32'hDEADBEEF);
        cyc();
        check("t4_we_once", 32'({mem_en, mem_we}), 32'd0);
        repeat (2) cyc();
        check("t4_dm_valid", 32'(dm_valid), 32'd1);
        check("t4_dm_rdata_kept", dm_rdata, rom(9'h040));
        dm_req = 1'b0; dm_we = 1'b0;
        cyc();

        // ---------------- 5: reset mid-transaction ----------------
        if_req = 1'b1; if_addr = 9'h060;
        push_cmd(1'b0, 1'b0, 9'h060, '0, 3'b010);
        cyc();
        cyc();
        reset = 1'b0;
        rsp_q.delete();
        last_dm = '0;
        #1;
        check("t5_outs_zero", 32'({mem_en, mem_we, if_valid, dm_valid, mem_funct3}), 32'd0);
        check("t5_data_zero", if_rdata | dm_rdata | mem_wdata | 32'(mem_addr), 32'd0);
        check("t5_stall_follows", 32'({if_stall, dm_stall}), 32'd2);
        if_req = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t5_quiet", 32'({mem_en, if_valid, dm_valid}), 32'd0);
        end

        // ---------------- 6: IF drops req mid-transaction ----------------
        if_req = 1'b1; if_addr = 9'h070;
        push_cmd(1'b0, 1'b0, 9'h070, '0, 3'b010);
        push_cmd(1'b1, 1'b0, 9'h080, '0, 3'b010);
        cyc();
        cyc();
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h080; dm_funct3 = 3'b010;
        cyc();
        cyc();
        check("t6_if_valid_t4", 32'({if_valid, dm_valid, dm_stall}), 32'd5);
        cyc();
        check("t6_dm_issue_t5", 32'({mem_en, mem_addr}), 32'({1'b1, 9'h080}));
        repeat (3) cyc();
        check("t6_dm_valid_t8", 32'(dm_valid), 32'd1);
        dm_req = 1'b0;
        repeat (3) cyc();

        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
